// File: rtl/led_ctrl.sv
//------------------------------------------------------------------------------
// led_ctrl -- multi-channel LED driver.
//
// Each channel can be OFF, ON, BLINK or ACTIVITY. In BLINK a bit of a shared
// tick counter is shown. In ACTIVITY a traffic pulse is stretched to a visible
// on-time, followed by a guaranteed off-time. A shared prescaler generates the
// time base, and a global PWM sets the brightness. The LED pins are driven
// from registers.
//
// Ports:
//   sysclk2        in   clock; all logic runs in this domain
//   sysclk2_rst_n  in   asynchronous active-low reset
//   cfg_wr         in   one-cycle strobe that latches cfg_mode/cfg_bsel/cfg_bright
//   cfg_mode       in   2 bits per channel: 0 OFF, 1 ON, 2 BLINK, 3 ACTIVITY
//   cfg_bsel       in   BSEL_W bits per channel: blink counter bit to display
//   cfg_bright     in   global brightness (all-ones = full, 0 = dark)
//   act_in         in   per-channel activity pulses (synchronous)
//   tick_o         out  one-cycle prescaler tick
//   led_o          out  registered LED drive, inverted when ACTIVE_LOW
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module led_ctrl #(
  parameter int NUM_LEDS   = 4,
  parameter int PRESCALE   = 100000,
  parameter int CNT_W      = 12,
  parameter int BSEL_W     = 4,
  parameter int STRETCH    = 50,
  parameter int PWM_W      = 4,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int RST_MODE   = 2,
  parameter int RST_BSEL   = 9
) (
  input  logic                       sysclk2,
  input  logic                       sysclk2_rst_n,
  input  logic                       cfg_wr,
  input  logic [2*NUM_LEDS-1:0]      cfg_mode,
  input  logic [BSEL_W*NUM_LEDS-1:0] cfg_bsel,
  input  logic [PWM_W-1:0]           cfg_bright,
  input  logic [NUM_LEDS-1:0]        act_in,
  output logic                       tick_o,
  output logic [NUM_LEDS-1:0]        led_o
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int SC_W = $clog2(STRETCH + 1);

  localparam logic [PS_W-1:0]   PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [SC_W-1:0]   SC_FULL    = SC_W'(STRETCH);
  localparam logic [SC_W-1:0]   SC_ONE     = SC_W'(1);
  localparam logic [1:0]        RST_MODE_L = 2'(RST_MODE);
  localparam logic [BSEL_W-1:0] RST_BSEL_L = BSEL_W'(RST_BSEL);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_ACT   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LIT  = 2'd1;
  localparam logic [1:0] ST_DARK = 2'd2;

  // Shared time base
  logic [PS_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0] blink_q, blink_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             tick;

  // Configuration
  logic [2*NUM_LEDS-1:0]      mode_q;
  logic [BSEL_W*NUM_LEDS-1:0] bsel_q;
  logic [PWM_W-1:0]           bright_q;

  logic [NUM_LEDS-1:0] raw_vec;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                en;

  // The tick is decoded from the count itself, so it is low in reset.
  assign tick    = (presc_q == PS_LAST);
  assign tick_o  = tick;
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign blink_d = blink_q + CNT_W'(tick);
  assign pwm_d   = pwm_q + 1'b1;

  // Full brightness bypasses the comparison, so it is a steady on.
  assign en = (bright_q == '1) | (pwm_q < bright_q);

  always_ff @(posedge sysclk2 or negedge sysclk2_rst_n) begin
    if (!sysclk2_rst_n) begin
      presc_q  <= '0;
      blink_q  <= '0;
      pwm_q    <= '0;
      mode_q   <= {NUM_LEDS{RST_MODE_L}};
      bsel_q   <= {NUM_LEDS{RST_BSEL_L}};
      bright_q <= '1;
      led_q    <= {NUM_LEDS{ACTIVE_LOW}};
    end else begin
      presc_q <= presc_d;
      blink_q <= blink_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      if (cfg_wr) begin
        mode_q   <= cfg_mode;
        bsel_q   <= cfg_bsel;
        bright_q <= cfg_bright;
      end
    end
  end

  assign led_d = (raw_vec & {NUM_LEDS{en}}) ^ {NUM_LEDS{ACTIVE_LOW}};
  assign led_o = led_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
      logic [1:0]        mode_ch;
      logic [1:0]        new_mode_ch;
      logic [BSEL_W-1:0] bsel_ch;
      logic [1:0]        st_q, st_d;
      logic [SC_W-1:0]   sc_q, sc_d;
      logic              pend_q, pend_d;
      logic              blink_bit;
      logic              raw_ch;
      logic [CNT_W-1:0]  shifted;
      int                sh;

      assign mode_ch     = mode_q[2*gi +: 2];
      assign new_mode_ch = cfg_mode[2*gi +: 2];
      assign bsel_ch     = bsel_q[BSEL_W*gi +: BSEL_W];

      // Out-of-range selects show the top counter bit (the slowest blink).
      always_comb begin
        sh = int'(bsel_ch);
        if (sh > CNT_W - 1) begin
          sh = CNT_W - 1;
        end
        shifted   = blink_q >> sh;
        blink_bit = shifted[0];
      end

      // Activity stretcher. The state is only advanced in ACTIVITY mode.
      // Any mode change parks it, so that entering ACTIVITY always starts from IDLE.
      always_comb begin
        st_d   = st_q;
        sc_d   = sc_q;
        pend_d = pend_q;
        if (mode_ch == MODE_ACT) begin
          case (st_q)
            ST_IDLE: begin
              if (act_in[gi]) begin
                st_d = ST_LIT;
                sc_d = SC_FULL;
              end
            end
            ST_LIT: begin
              if (act_in[gi]) begin
                pend_d = 1'b1;
              end
              if (tick) begin
                if (sc_q == SC_ONE) begin
                  st_d = ST_DARK;
                  sc_d = SC_FULL;
                end else begin
                  sc_d = sc_q - 1'b1;
                end
              end
            end
            ST_DARK: begin
              if (act_in[gi]) begin
                pend_d = 1'b1;
              end
              if (tick) begin
                if (sc_q == SC_ONE) begin
                  // Activity arriving on the expiry cycle itself also counts
                  // as pending.
                  pend_d = 1'b0;
                  if (pend_q || act_in[gi]) begin
                    st_d = ST_LIT;
                    sc_d = SC_FULL;
                  end else begin
                    st_d = ST_IDLE;
                    sc_d = '0;
                  end
                end else begin
                  sc_d = sc_q - 1'b1;
                end
              end
            end
            default: begin
              st_d   = ST_IDLE;
              sc_d   = '0;
              pend_d = 1'b0;
            end
          endcase
        end
        if (cfg_wr && (new_mode_ch != mode_ch)) begin
          st_d   = ST_IDLE;
          sc_d   = '0;
          pend_d = 1'b0;
        end
      end

      always_ff @(posedge sysclk2 or negedge sysclk2_rst_n) begin
        if (!sysclk2_rst_n) begin
          st_q   <= ST_IDLE;
          sc_q   <= '0;
          pend_q <= 1'b0;
        end else begin
          st_q   <= st_d;
          sc_q   <= sc_d;
          pend_q <= pend_d;
        end
      end

      always_comb begin
        case (mode_ch)
          MODE_OFF:   raw_ch = 1'b0;
          MODE_ON:    raw_ch = 1'b1;
          MODE_BLINK: raw_ch = blink_bit;
          default:    raw_ch = (st_q == ST_LIT);
        endcase
      end

      assign raw_vec[gi] = raw_ch;
    end
  endgenerate

endmodule

// File: tb/tb_led_ctrl.sv
`timescale 1ns/1ps

module tb_led_ctrl;

  localparam int PS = 4;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [7:0]  cfg_mode = '0;
  logic [15:0] cfg_bsel = '0;
  logic [1:0]  cfg_bright = '0;
  logic [3:0]  act_in = '0;
  logic        tick, tick_al;
  logic [3:0]  led, led_al;

  always #5 clk = ~clk;

  led_ctrl #(.NUM_LEDS(4), .PRESCALE(4), .CNT_W(4), .BSEL_W(4), .STRETCH(3),
             .PWM_W(2), .ACTIVE_LOW(1'b0), .RST_MODE(2), .RST_BSEL(1)) dut (
    .sysclk2(clk), .sysclk2_rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_bsel(cfg_bsel), .cfg_bright(cfg_bright), .act_in(act_in),
    .tick_o(tick), .led_o(led));

  led_ctrl #(.NUM_LEDS(4), .PRESCALE(4), .CNT_W(4), .BSEL_W(4), .STRETCH(3),
             .PWM_W(2), .ACTIVE_LOW(1'b1), .RST_MODE(2), .RST_BSEL(1)) dut_al (
    .sysclk2(clk), .sysclk2_rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_bsel(cfg_bsel), .cfg_bright(cfg_bright), .act_in(act_in),
    .tick_o(tick_al), .led_o(led_al));

  // Reference model: time is tracked as the number of clock edges since reset
  // release. Ticks, the blink value and the PWM phase follow arithmetically from that count.
  // Activity is tracked as a phase plus the absolute tick number at which the phase ends.
  int k;
  int m_mode[4];
  int m_bsel[4];
  int m_bright;
  int a_phase[4];   // 0 idle, 1 lit, 2 dark
  int a_end[4];
  bit a_pend[4];
  logic [3:0] exp_led;
  logic       exp_tick;

  int vectors = 0;
  int errors  = 0;

  function automatic void model_reset();
    k = 0;
    m_bright = 3;
    for (int i = 0; i < 4; i++) begin
      m_mode[i]  = 2;
      m_bsel[i]  = 1;
      a_phase[i] = 0;
      a_end[i]   = 0;
      a_pend[i]  = 1'b0;
    end
    exp_led  = 4'h0;
    exp_tick = 1'b0;
  endfunction

  function automatic void model_edge(input logic wr, input logic [7:0] mode,
                                     input logic [15:0] bsel, input logic [1:0] bright,
                                     input logic [3:0] a);
    bit tk;
    bit en;
    bit raw;
    int t_after;
    int blink;
    int pwm;
    int b;
    int nm;
    tk      = ((k % PS) == PS - 1);
    t_after = k / PS + (tk ? 1 : 0);
    blink   = (k / PS) % 16;
    pwm     = k % 4;
    en      = (m_bright == 3) || (pwm < m_bright);
    for (int i = 0; i < 4; i++) begin
      case (m_mode[i])
        0: raw = 1'b0;
        1: raw = 1'b1;
        2: begin
          b   = (m_bsel[i] > 3) ? 3 : m_bsel[i];
          raw = (((blink >> b) & 1) != 0);
        end
        default: raw = (a_phase[i] == 1);
      endcase
      exp_led[i] = raw & en;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_mode[i] == 3) begin
        case (a_phase[i])
          0: if (a[i]) begin
            a_phase[i] = 1;
            a_end[i]   = t_after + ST;
          end
          1: begin
            if (a[i]) a_pend[i] = 1'b1;
            if (tk && t_after == a_end[i]) begin
              a_phase[i] = 2;
              a_end[i]   = a_end[i] + ST;
            end
          end
          default: begin
            if (a[i]) a_pend[i] = 1'b1;
            if (tk && t_after == a_end[i]) begin
              if (a_pend[i]) begin
                a_phase[i] = 1;
                a_end[i]   = t_after + ST;
              end else begin
                a_phase[i] = 0;
              end
              a_pend[i] = 1'b0;
            end
          end
        endcase
      end
    end
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        nm = int'(mode[2*i +: 2]);
        if (nm != m_mode[i]) begin
          a_phase[i] = 0;
          a_pend[i]  = 1'b0;
        end
        m_mode[i] = nm;
        m_bsel[i] = int'(bsel[4*i +: 4]);
      end
      m_bright = int'(bright);
    end
    k++;
    exp_tick = ((k % PS) == PS - 1);
  endfunction

  task automatic step(input logic wr, input logic [7:0] mode, input logic [15:0] bsel,
                      input logic [1:0] bright, input logic [3:0] a);
    cfg_wr     = wr;
    cfg_mode   = mode;
    cfg_bsel   = bsel;
    cfg_bright = bright;
    act_in     = a;
    @(posedge clk);
    model_edge(wr, mode, bsel, bright, a);
    #1;
    cfg_wr = 1'b0;
    act_in = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (led !== 4'h0) begin
      errors++; $display("FAIL reset_led got=%b want=0000", led);
    end
    vectors++;
    if (led_al !== 4'hF) begin
      errors++; $display("FAIL reset_led_al got=%b want=1111", led_al);
    end
    vectors++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got=%b want=0", tick);
    end
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led || led_al !== ~exp_led || tick !== exp_tick) begin
        errors++;
        $display("FAIL reset_blink cyc=%0d led=%b al=%b tick=%b want led=%b tick=%b",
                 k, led, led_al, tick, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_cfg_on_off();
    int hi;
    // ch0 ON, ch1 OFF, ch2/ch3 BLINK
    step(1'b1, 8'b10_10_00_01, 16'h1111, 2'd3, 4'h0);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led || tick !== exp_tick) begin
        errors++;
        $display("FAIL on_off cyc=%0d led=%b tick=%b want led=%b tick=%b",
                 k, led, tick, exp_led, exp_tick);
      end
    end
    step(1'b1, 8'b10_10_00_01, 16'h1111, 2'd1, 4'h0);
    hi = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      hi += int'(led[0]);
      vectors++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL pwm_quarter cyc=%0d led=%b want=%b", k, led, exp_led);
      end
    end
    vectors++;
    if (hi != 4) begin
      errors++; $display("FAIL pwm_duty high_cycles=%0d want=4", hi);
    end
    step(1'b1, 8'b10_10_00_01, 16'h1111, 2'd0, 4'h0);
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led || led_al !== ~exp_led) begin
        errors++;
        $display("FAIL bright_zero cyc=%0d led=%b al=%b want=%b", k, led, led_al, exp_led);
      end
    end
  endtask

  task automatic test_activity();
    step(1'b1, 8'hFF, 16'h0, 2'd3, 4'h0);
    repeat ($urandom_range(0, 3)) step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
    step(1'b0, 8'h0, 16'h0, 2'd0, 4'b0100);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led) begin
        errors++; $display("FAIL act_single cyc=%0d led=%b want=%b", k, led, exp_led);
      end
    end
    for (int c = 0; c < 60; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'b0100);
      vectors++;
      if (led !== exp_led) begin
        errors++; $display("FAIL act_held cyc=%0d led=%b want=%b", k, led, exp_led);
      end
    end
    for (int c = 0; c < 50; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led) begin
        errors++; $display("FAIL act_drain cyc=%0d led=%b want=%b", k, led, exp_led);
      end
    end
  endtask

  task automatic test_pending();
    // Second pulse during the off-period, then a second pulse during the on-period.
    for (int r = 0; r < 2; r++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'b0100);
      for (int c = 0; c < 60; c++) begin
        step(1'b0, 8'h0, 16'h0, 2'd0,
             (c == ((r == 0) ? 15 : 4)) ? 4'b0100 : 4'h0);
        vectors++;
        if (led !== exp_led) begin
          errors++;
          $display("FAIL act_pending r=%0d cyc=%0d led=%b want=%b", r, k, led, exp_led);
        end
      end
    end
  endtask

  task automatic test_bsel_clamp();
    // ch0 bsel=7 (clamped), ch1 bsel=3, ch2 bsel=0, ch3 bsel=15
    step(1'b1, 8'hAA, 16'hF037, 2'd3, 4'h0);
    for (int c = 0; c < 300; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led || led[0] !== led[1]) begin
        errors++;
        $display("FAIL bsel_clamp cyc=%0d led=%b want=%b", k, led, exp_led);
      end
    end
  endtask

  task automatic test_midreset();
    step(1'b1, 8'hFF, 16'h0, 2'd3, 4'h0);
    step(1'b0, 8'h0, 16'h0, 2'd0, 4'b0100);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led) begin
        errors++; $display("FAIL midrst_lit cyc=%0d led=%b want=%b", k, led, exp_led);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (led !== 4'h0 || led_al !== 4'hF) begin
      errors++; $display("FAIL midrst_async led=%b al=%b want 0000/1111", led, led_al);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, (c == 10) ? 4'b0100 : 4'h0);
      vectors++;
      if (led !== exp_led || tick !== exp_tick) begin
        errors++;
        $display("FAIL midrst_after cyc=%0d led=%b tick=%b want led=%b tick=%b",
                 k, led, tick, exp_led, exp_tick);
      end
    end
    step(1'b1, 8'hFF, 16'h0, 2'd3, 4'h0);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led) begin
        errors++; $display("FAIL midrst_idle cyc=%0d led=%b want=%b", k, led, exp_led);
      end
    end
  endtask

  task automatic test_cfg_tick();
    step(1'b1, 8'hAA, 16'h0000, 2'd3, 4'h0);
    for (int c = 0; c < 8 && exp_tick !== 1'b1; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
    end
    vectors++;
    if (tick !== 1'b1 || exp_tick !== 1'b1) begin
      errors++; $display("FAIL cfg_tick_align tick=%b want=1", tick);
    end
    // ch0 BLINK -> ON on the tick edge; ch1 keeps blinking on bit 0.
    step(1'b1, 8'b10_10_10_01, 16'h0000, 2'd3, 4'h0);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 8'h0, 16'h0, 2'd0, 4'h0);
      vectors++;
      if (led !== exp_led || tick !== exp_tick) begin
        errors++;
        $display("FAIL cfg_tick cyc=%0d led=%b tick=%b want led=%b tick=%b",
                 k, led, tick, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_random();
    logic        wr;
    logic [7:0]  mode;
    logic [15:0] bsel;
    logic [1:0]  bright;
    logic [3:0]  a;
    for (int c = 0; c < 1500; c++) begin
      wr     = ($urandom_range(0, 39) == 0);
      mode   = 8'($urandom);
      bsel   = 16'($urandom);
      bright = 2'($urandom);
      a      = 4'($urandom & $urandom & $urandom);
      step(wr, mode, bsel, bright, a);
      vectors++;
      if (led !== exp_led || led_al !== ~exp_led || tick !== exp_tick) begin
        errors++;
        $display("FAIL random cyc=%0d led=%b al=%b tick=%b want led=%b tick=%b",
                 k, led, led_al, tick, exp_led, exp_tick);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cfg_on_off();
    test_activity();
    test_pending();
    test_bsel_clamp();
    test_midreset();
    test_cfg_tick();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
